// File: rtl/modbus_hr_arbiter.sv
// Round-robin arbiter sharing one single-port holding-register RAM between the
// Modbus TX reader, the Modbus RX writer and the application port.
module modbus_hr_arbiter #(
   parameter int AW       = 8,
   parameter int HR_DEPTH = 256,
   parameter int LOCK_MAX = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_req,
   input  logic [15:0]   rd_a,
   output logic          rd_gnt,
   output logic          rd_ack,
   output logic [15:0]   rd_q,
   output logic          rd_err,
   input  logic          wr_req,
   input  logic [15:0]   wr_a,
   input  logic [15:0]   wr_d,
   output logic          wr_gnt,
   output logic          wr_ack,
   output logic          wr_err,
   input  logic          app_req,
   input  logic          app_we,
   input  logic [15:0]   app_a,
   input  logic [15:0]   app_d,
   output logic          app_gnt,
   output logic          app_ack,
   output logic [15:0]   app_q,
   output logic          app_err,
   input  logic          mb_lock,
   output logic          lock_to,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [15:0]   mem_d,
   input  logic [15:0]   mem_q
);

   localparam logic [1:0] ID_WR  = 2'd0;
   localparam logic [1:0] ID_RD  = 2'd1;
   localparam logic [1:0] ID_APP = 2'd2;
   localparam int         LCW    = $clog2(LOCK_MAX) + 1;

   logic            r_wr_gnt, r_rd_gnt, r_app_gnt;
   logic            r_wr_ack, r_rd_ack, r_app_ack;
   logic            r_wr_err, r_rd_err, r_app_err, r_app_rd;
   logic [15:0]     r_rd_q, r_app_q;
   logic            r_mem_en, r_mem_we;
   logic [AW-1:0]   r_mem_a;
   logic [15:0]     r_mem_d;
   logic [1:0]      r_last;
   logic            r_pend_vld, r_pend_rd, r_pend_err;
   logic [1:0]      r_pend_id;
   logic [LCW-1:0]  r_lock_cnt;
   logic            r_lock_to;

   logic [2:0]      w_elig;
   logic [1:0]      w_o0, w_o1, w_o2;
   logic            w_sel_vld, w_sel_we, w_in_range;
   logic [1:0]      w_sel_id;
   logic [15:0]     w_sel_a, w_sel_d, w_rd_q, w_app_q;

   // A requester granted last cycle may still show req high; mask it so one
   // request is never granted twice.
   assign w_elig[ID_WR]  = wr_req  & ~r_wr_gnt;
   assign w_elig[ID_RD]  = rd_req  & ~r_rd_gnt;
   assign w_elig[ID_APP] = app_req & ~r_app_gnt & (~mb_lock | r_lock_to);

   always_comb begin
      w_o0 = ID_WR;
      w_o1 = ID_RD;
      w_o2 = ID_APP;
      case (r_last)
         ID_WR:   begin w_o0 = ID_RD;  w_o1 = ID_APP; w_o2 = ID_WR;  end
         ID_RD:   begin w_o0 = ID_APP; w_o1 = ID_WR;  w_o2 = ID_RD;  end
         default: begin w_o0 = ID_WR;  w_o1 = ID_RD;  w_o2 = ID_APP; end
      endcase
      w_sel_vld = 1'b1;
      w_sel_id  = w_o0;
      if (w_elig[w_o0]) begin
         w_sel_id = w_o0;
      end else if (w_elig[w_o1]) begin
         w_sel_id = w_o1;
      end else if (w_elig[w_o2]) begin
         w_sel_id = w_o2;
      end else begin
         w_sel_vld = 1'b0;
      end
   end

   always_comb begin
      w_sel_a  = app_a;
      w_sel_d  = app_d;
      w_sel_we = app_we;
      case (w_sel_id)
         ID_WR:   begin w_sel_a = wr_a; w_sel_d = wr_d;  w_sel_we = 1'b1; end
         ID_RD:   begin w_sel_a = rd_a; w_sel_d = 16'h0; w_sel_we = 1'b0; end
         default: begin w_sel_a = app_a; w_sel_d = app_d; w_sel_we = app_we; end
      endcase
      w_in_range = ({16'h0, w_sel_a} < $unsigned(32'(HR_DEPTH)));
   end

   // RAM data arrives during the ack cycle, so read data is forwarded then held.
   assign w_rd_q  = r_rd_ack ? (r_rd_err ? 16'h0 : mem_q) : r_rd_q;
   assign w_app_q = (r_app_ack && r_app_rd) ? (r_app_err ? 16'h0 : mem_q) : r_app_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_gnt   <= 1'b0;  r_rd_gnt  <= 1'b0;  r_app_gnt <= 1'b0;
         r_wr_ack   <= 1'b0;  r_rd_ack  <= 1'b0;  r_app_ack <= 1'b0;
         r_wr_err   <= 1'b0;  r_rd_err  <= 1'b0;  r_app_err <= 1'b0;
         r_app_rd   <= 1'b0;
         r_rd_q     <= 16'h0; r_app_q   <= 16'h0;
         r_mem_en   <= 1'b0;  r_mem_we  <= 1'b0;
         r_mem_a    <= '0;    r_mem_d   <= 16'h0;
         r_last     <= ID_APP;
         r_pend_vld <= 1'b0;  r_pend_rd <= 1'b0;  r_pend_err <= 1'b0;
         r_pend_id  <= ID_WR;
         r_lock_cnt <= '0;    r_lock_to <= 1'b0;
      end else begin
         r_wr_gnt  <= w_sel_vld && (w_sel_id == ID_WR);
         r_rd_gnt  <= w_sel_vld && (w_sel_id == ID_RD);
         r_app_gnt <= w_sel_vld && (w_sel_id == ID_APP);
         if (w_sel_vld) begin
            r_last   <= w_sel_id;
            r_mem_en <= w_in_range;
            r_mem_we <= w_in_range & w_sel_we;
            r_mem_a  <= w_sel_a[AW-1:0];
            r_mem_d  <= w_sel_d;
         end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
         end
         r_pend_vld <= w_sel_vld;
         r_pend_id  <= w_sel_id;
         r_pend_rd  <= ~w_sel_we;
         r_pend_err <= ~w_in_range;

         r_wr_ack  <= r_pend_vld && (r_pend_id == ID_WR);
         r_rd_ack  <= r_pend_vld && (r_pend_id == ID_RD);
         r_app_ack <= r_pend_vld && (r_pend_id == ID_APP);
         r_wr_err  <= r_pend_vld && (r_pend_id == ID_WR)  && r_pend_err;
         r_rd_err  <= r_pend_vld && (r_pend_id == ID_RD)  && r_pend_err;
         r_app_err <= r_pend_vld && (r_pend_id == ID_APP) && r_pend_err;
         r_app_rd  <= r_pend_rd;
         r_rd_q    <= w_rd_q;
         r_app_q   <= w_app_q;

         // Timeout fires when the count reaches LOCK_MAX-1, then saturates.
         if (!mb_lock) begin
            r_lock_cnt <= '0;
            r_lock_to  <= 1'b0;
         end else if (app_req && !r_lock_to) begin
            r_lock_cnt <= r_lock_cnt + LCW'(1);
            r_lock_to  <= (r_lock_cnt == LCW'(LOCK_MAX - 2));
         end else begin
            r_lock_cnt <= r_lock_cnt;
         end
      end
   end

   assign wr_gnt  = r_wr_gnt;
   assign rd_gnt  = r_rd_gnt;
   assign app_gnt = r_app_gnt;
   assign wr_ack  = r_wr_ack;
   assign rd_ack  = r_rd_ack;
   assign app_ack = r_app_ack;
   assign wr_err  = r_wr_err;
   assign rd_err  = r_rd_err;
   assign app_err = r_app_err;
   assign rd_q    = w_rd_q;
   assign app_q   = w_app_q;
   assign lock_to = r_lock_to;
   assign mem_en  = r_mem_en;
   assign mem_we  = r_mem_we;
   assign mem_a   = r_mem_a;
   assign mem_d   = r_mem_d;

endmodule
